// File: rtl/seven_seg_scan_decoder.sv
// Receive-side monitor for a multiplexed 4-digit 7-segment bus: settles, decodes and rebuilds frames.
// Optional result extraction is built only when SEGDEC_RESULT_EN is defined.
module seven_seg_scan_decoder #(
    parameter int unsigned SETTLE        = 4,
    parameter int unsigned STABLE_FRAMES = 2,
    parameter int unsigned TIMEOUT       = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  digit,
    input  logic [6:0]  display,
    output logic [15:0] frame,
    output logic        frame_valid,
    output logic        frame_stable,
    output logic        locked,
    output logic        err_code,
    output logic        err_digit,
    output logic        err_order,
    output logic [3:0]  res_a,
    output logic [3:0]  res_b,
    output logic        res_valid
);

    localparam int unsigned DW = $clog2(SETTLE + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned MW = $clog2(STABLE_FRAMES + 1);

    localparam logic [0:0] HUNT    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    logic [3:0]    digit_q, digit_p;
    logic [6:0]    display_q, display_p;
    logic [DW-1:0] dwell;
    logic [TW-1:0] to_cnt;
    logic [MW-1:0] match_cnt;
    logic [0:0]    state, state_n;
    logic [1:0]    exp_slot, exp_n;
    logic [11:0]   part;

    logic          changed_c, legal_c, idle_c, sample_c, bad_digit_c, bad_code_c;
    logic [1:0]    slot_c;
    logic [3:0]    code_c;
    logic [15:0]   new_frame_c;
    logic          store_c, complete_c, order_err_c;
    logic [MW-1:0] match_n;

    function automatic logic [3:0] glyph_code(input logic [6:0] seg);
        case (seg)
            7'h40:   glyph_code = 4'd0;
            7'h79:   glyph_code = 4'd1;
            7'h24:   glyph_code = 4'd2;
            7'h30:   glyph_code = 4'd3;
            7'h19:   glyph_code = 4'd4;
            7'h12:   glyph_code = 4'd5;
            7'h02:   glyph_code = 4'd6;
            7'h78:   glyph_code = 4'd7;
            7'h00:   glyph_code = 4'd8;
            7'h10:   glyph_code = 4'd9;
            7'h08:   glyph_code = 4'd10;
            7'h03:   glyph_code = 4'd11;
            7'h3F:   glyph_code = 4'd12;
            7'h7F:   glyph_code = 4'd15;
            default: glyph_code = 4'd14;
        endcase
    endfunction

    // Input qualification: slot decode, dwell-based sampling, glyph decode
    always_comb begin
        legal_c = 1'b1;
        slot_c  = 2'd0;
        case (digit_q)
            4'b1110: slot_c = 2'd0;
            4'b1101: slot_c = 2'd1;
            4'b1011: slot_c = 2'd2;
            4'b0111: slot_c = 2'd3;
            default: legal_c = 1'b0;
        endcase
        idle_c      = (digit_q == 4'b1111);
        changed_c   = (digit_q != digit_p) || (display_q != display_p);
        sample_c    = legal_c && !changed_c && (dwell == DW'(SETTLE - 1));
        bad_digit_c = !legal_c && !idle_c && changed_c;
        code_c      = glyph_code(display_q);
        bad_code_c  = (code_c == 4'd14);
        new_frame_c = {code_c, part};
    end

    // Next-state logic for the slot sequencer
    always_comb begin
        state_n     = state;
        exp_n       = exp_slot;
        store_c     = 1'b0;
        complete_c  = 1'b0;
        order_err_c = 1'b0;
        if (bad_digit_c) begin
            state_n = HUNT;
        end else if (sample_c) begin
            if (state == HUNT) begin
                if (slot_c == 2'd0) begin
                    store_c = 1'b1;
                    exp_n   = 2'd1;
                    state_n = COLLECT;
                end
            end else if (slot_c == exp_slot) begin
                store_c    = 1'b1;
                exp_n      = slot_c + 2'd1;
                complete_c = (slot_c == 2'd3);
            end else begin
                order_err_c = 1'b1;
                state_n     = HUNT;
            end
        end else if (state == COLLECT && to_cnt == TW'(TIMEOUT - 1)) begin
            state_n = HUNT;
        end
    end

    // Consecutive-identical-frame count; cleared whenever lock is lost
    always_comb begin
        match_n = match_cnt;
        if (state_n != COLLECT) begin
            match_n = '0;
        end else if (complete_c) begin
            if (match_cnt == '0 || new_frame_c != frame)
                match_n = MW'(1);
            else if (match_cnt != MW'(STABLE_FRAMES))
                match_n = match_cnt + MW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= HUNT;
            exp_slot <= 2'd0;
        end else begin
            state    <= state_n;
            exp_slot <= exp_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            digit_q      <= 4'b1111;
            digit_p      <= 4'b1111;
            display_q    <= 7'h7F;
            display_p    <= 7'h7F;
            dwell        <= '0;
            to_cnt       <= '0;
            match_cnt    <= '0;
            part         <= '0;
            frame        <= 16'hCCCC;
            frame_valid  <= 1'b0;
            frame_stable <= 1'b0;
            locked       <= 1'b0;
            err_code     <= 1'b0;
            err_digit    <= 1'b0;
            err_order    <= 1'b0;
        end else begin
            digit_q   <= digit;
            display_q <= display;
            digit_p   <= digit_q;
            display_p <= display_q;

            if (changed_c || !legal_c)
                dwell <= '0;
            else if (dwell != DW'(SETTLE))
                dwell <= dwell + DW'(1);

            if (sample_c || state != COLLECT)
                to_cnt <= '0;
            else if (to_cnt != TW'(TIMEOUT))
                to_cnt <= to_cnt + TW'(1);

            if (store_c) begin
                case (slot_c)
                    2'd0:    part[3:0]  <= code_c;
                    2'd1:    part[7:4]  <= code_c;
                    2'd2:    part[11:8] <= code_c;
                    default: ;
                endcase
            end
            if (complete_c)
                frame <= new_frame_c;

            frame_valid  <= complete_c;
            match_cnt    <= match_n;
            frame_stable <= (match_n == MW'(STABLE_FRAMES));
            locked       <= (state_n == COLLECT);
            err_code     <= sample_c && bad_code_c;
            err_digit    <= bad_digit_c;
            err_order    <= order_err_c;
        end
    end

`ifdef SEGDEC_RESULT_EN
    // Result frame pattern: slot2 = 'A', slot0 = 'b'
    always_ff @(posedge clk) begin
        if (!rst) begin
            res_a     <= 4'd0;
            res_b     <= 4'd0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (complete_c && new_frame_c[11:8] == 4'd10 && new_frame_c[3:0] == 4'd11) begin
                res_a     <= new_frame_c[15:12];
                res_b     <= new_frame_c[7:4];
                res_valid <= 1'b1;
            end
        end
    end
`else
    assign res_a     = 4'd0;
    assign res_b     = 4'd0;
    assign res_valid = 1'b0;
`endif

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Scoreboard bench for seven_seg_scan_decoder: expected frames queued at scan time, checked on frame_valid.
module tb_seven_seg_scan_decoder;

    localparam int unsigned TO = 2000;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  digit;
    logic [6:0]  display;
    logic [15:0] frame;
    logic        frame_valid, frame_stable, locked;
    logic        err_code, err_digit, err_order;
    logic [3:0]  res_a, res_b;
    logic        res_valid;

    always #5 clk = ~clk;

    seven_seg_scan_decoder #(.SETTLE(4), .STABLE_FRAMES(2), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .digit(digit), .display(display),
        .frame(frame), .frame_valid(frame_valid), .frame_stable(frame_stable),
        .locked(locked), .err_code(err_code), .err_digit(err_digit),
        .err_order(err_order), .res_a(res_a), .res_b(res_b), .res_valid(res_valid)
    );

    typedef struct packed {
        logic [15:0] frame;
        logic        stable;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cnt_fv = 0, cnt_ec = 0, cnt_ed = 0, cnt_eo = 0, cnt_rv = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0:    seg_of = 7'h40;
            4'd1:    seg_of = 7'h79;
            4'd2:    seg_of = 7'h24;
            4'd3:    seg_of = 7'h30;
            4'd4:    seg_of = 7'h19;
            4'd5:    seg_of = 7'h12;
            4'd6:    seg_of = 7'h02;
            4'd7:    seg_of = 7'h78;
            4'd8:    seg_of = 7'h00;
            4'd9:    seg_of = 7'h10;
            4'd10:   seg_of = 7'h08;
            4'd11:   seg_of = 7'h03;
            4'd12:   seg_of = 7'h3F;
            default: seg_of = 7'h7F;
        endcase
    endfunction

    // Pulse counters and scoreboard pop, sampled on the inactive edge
    always @(negedge clk) begin
        if (rst) begin
            if (err_code)  cnt_ec++;
            if (err_digit) cnt_ed++;
            if (err_order) cnt_eo++;
            if (res_valid) cnt_rv++;
            if (frame_valid) begin
                exp_t e;
                cnt_fv++;
                if (sb.size() == 0) begin
                    check_eq("unexpected_frame_valid", 32'(frame_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("sb_frame", 32'(frame), 32'(e.frame));
                    check_eq("sb_stable", 32'(frame_stable), 32'(e.stable));
                end
            end
        end
    end

    task automatic drive_slot(input int slot, input logic [6:0] seg, input int n);
        logic [3:0] d;
        d       = 4'b0001 << slot;
        digit   = ~d;
        display = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [15:0] f, input logic stable_exp);
        exp_t e;
        for (int s = 0; s < 4; s++) begin
            if (s == 3) begin
                e.frame  = f;
                e.stable = stable_exp;
                sb.push_back(e);
            end
            drive_slot(s, seg_of(f[s*4 +: 4]), 8);
        end
    endtask

    initial begin
        int base;
        exp_t e;
        rst     = 1'b0;
        digit   = 4'b1111;
        display = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_frame", 32'(frame), 32'hCCCC);
        check_eq("rst_locked", 32'(locked), 32'd0);
        check_eq("rst_stable", 32'(frame_stable), 32'd0);
        check_eq("rst_res_a", 32'(res_a), 32'd0);
        rst = 1'b1;

        // 1: steady "1234" scan
        scan(16'h1234, 1'b0);
        scan(16'h1234, 1'b1);
        scan(16'h1234, 1'b1);
        check_eq("t1_fv_count", 32'(cnt_fv), 32'd3);
        check_eq("t1_frame", 32'(frame), 32'h1234);
        check_eq("t1_stable", 32'(frame_stable), 32'd1);
        check_eq("t1_locked", 32'(locked), 32'd1);
        check_eq("t1_errors", 32'(cnt_ec + cnt_ed + cnt_eo), 32'd0);

        // Reset mid-frame
        drive_slot(0, seg_of(4'd9), 8);
        rst     = 1'b0;
        digit   = 4'b1111;
        display = 7'h7F;
        repeat (2) @(posedge clk);
        #1;
        check_eq("midrst_frame", 32'(frame), 32'hCCCC);
        check_eq("midrst_locked", 32'(locked), 32'd0);
        rst = 1'b1;

        // 2: start at slot2, ignored until slot0
        drive_slot(2, seg_of(4'd6), 8);
        drive_slot(3, seg_of(4'd5), 8);
        check_eq("t2_hunt_locked", 32'(locked), 32'd0);
        check_eq("t2_no_early_fv", 32'(cnt_fv), 32'd3);
        scan(16'h5678, 1'b0);
        check_eq("t2_locked", 32'(locked), 32'd1);
        check_eq("t2_err_order", 32'(cnt_eo), 32'd0);

        // 3: skip slot1
        base = cnt_eo;
        drive_slot(0, seg_of(4'd4), 8);
        drive_slot(2, seg_of(4'd4), 8);
        check_eq("t3_err_order", 32'(cnt_eo - base), 32'd1);
        check_eq("t3_locked", 32'(locked), 32'd0);
        check_eq("t3_frame_kept", 32'(frame), 32'h5678);
        check_eq("t3_stable", 32'(frame_stable), 32'd0);

        // 4: bad glyph on slot1
        base = cnt_ec;
        drive_slot(0, seg_of(4'd1), 8);
        drive_slot(1, 7'h55, 8);
        drive_slot(2, seg_of(4'd2), 8);
        e.frame  = 16'h32E1;
        e.stable = 1'b0;
        sb.push_back(e);
        drive_slot(3, seg_of(4'd3), 8);
        check_eq("t4_err_code", 32'(cnt_ec - base), 32'd1);
        check_eq("t4_frame", 32'(frame), 32'h32E1);
        check_eq("t4_locked", 32'(locked), 32'd1);

        // 5: illegal anode pattern, then idle
        base    = cnt_ed;
        digit   = 4'b1100;
        display = 7'h7F;
        repeat (8) @(posedge clk);
        #1;
        check_eq("t5_err_digit", 32'(cnt_ed - base), 32'd1);
        check_eq("t5_locked", 32'(locked), 32'd0);
        digit = 4'b1111;
        repeat (8) @(posedge clk);
        #1;
        check_eq("t5_idle_no_err", 32'(cnt_ed - base), 32'd1);

        // 6: result frame then freeze until timeout
        base = cnt_rv;
        scan(16'h3A1B, 1'b0);
        scan(16'h3A1B, 1'b1);
        check_eq("t6_stable", 32'(frame_stable), 32'd1);
`ifdef SEGDEC_RESULT_EN
        check_eq("t6_res_valid", 32'(cnt_rv - base), 32'd2);
        check_eq("t6_res_a", 32'(res_a), 32'd3);
        check_eq("t6_res_b", 32'(res_b), 32'd1);
`else
        check_eq("t6_res_valid", 32'(cnt_rv - base), 32'd0);
        check_eq("t6_res_a", 32'(res_a), 32'd0);
        check_eq("t6_res_b", 32'(res_b), 32'd0);
`endif
        repeat (TO / 2) @(posedge clk);
        #1;
        check_eq("t6_still_locked", 32'(locked), 32'd1);
        for (int i = 0; i < int'(TO) && locked; i++) @(posedge clk);
        #1;
        check_eq("t6_timeout_locked", 32'(locked), 32'd0);
        check_eq("t6_timeout_stable", 32'(frame_stable), 32'd0);
        check_eq("t6_frame_kept", 32'(frame), 32'h3A1B);
`ifdef SEGDEC_RESULT_EN
        check_eq("t6_res_hold", 32'(res_a), 32'd3);
`endif

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
